// File: rtl/gpio_mulcnt_acc.sv
// rtl/gpio_mulcnt_acc.sv - bus-mapped iterative shift-add multiplier with stepped popcount
`timescale 1ns/1ps
module gpio_mulcnt_acc #(
   parameter int          OP_W    = 24,
   parameter int          DATA_W  = 32,
   parameter int          PC_STEP = 8,
   parameter int          CNT_W   = 16,
   parameter logic [15:0] BASE    = 16'h0380
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic [15:0]       saddress,
   input  logic              srd,
   input  logic              swr,
   input  logic [DATA_W-1:0] sdata_in,
   output logic [DATA_W-1:0] sdata_out,
   input  logic [DATA_W-1:0] gpio_in,
   input  logic              gpio_latch,
   output logic [DATA_W-1:0] gpio_out,
   output logic [DATA_W-1:0] gpio_in_s_insp
);
   localparam int P_W  = 2 * OP_W;
   localparam int N_SL = DATA_W / PC_STEP;
   localparam int MC_W = $clog2(OP_W + 1);
   localparam int SC_W = $clog2(N_SL + 1);

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_COUNT, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        rd_sy, wr_sy, lt_sy;
   logic              rd_edge, wr_edge, lt_edge;
   logic              hit_a1, hit_a2, hit_w, hit_l, hit_ctrl, hit_whi;
   logic              start;
   logic [OP_W-1:0]   a1_q, a2_q, mplier;
   logic [P_W-1:0]    mcand, acc, acc_nxt;
   logic [DATA_W-1:0] w_q, whi_q, l_q, pc_sh, slice_pop, rd_val;
   logic [MC_W-1:0]   mul_cnt;
   logic [SC_W-1:0]   sl_cnt;
   logic              err, busy, ready, valid;
   logic [CNT_W-1:0]  op_count;
   logic              unused_sdata;

   // Third flop of each chain holds the previous synced value for edge detection.
   assign rd_edge = rd_sy[1] & ~rd_sy[2];
   assign wr_edge = wr_sy[1] & ~wr_sy[2];
   assign lt_edge = lt_sy[1] & ~lt_sy[2];

   assign hit_a1   = (saddress == BASE);
   assign hit_a2   = (saddress == BASE + 16'h0008);
   assign hit_w    = (saddress == BASE + 16'h0010);
   assign hit_l    = (saddress == BASE + 16'h0018);
   assign hit_ctrl = (saddress == BASE + 16'h0020);
   assign hit_whi  = (saddress == BASE + 16'h0028);

   assign start        = wr_edge & hit_ctrl;
   assign acc_nxt      = mplier[0] ? (acc + mcand) : acc;
   assign gpio_out     = DATA_W'(op_count);
   assign unused_sdata = ^sdata_in;

   always_comb begin
      slice_pop = '0;
      for (int i = 0; i < PC_STEP; i++) begin
         slice_pop = slice_pop + DATA_W'(pc_sh[i]);
      end
   end

   always_comb begin
      rd_val = '0;
      if (hit_w)         rd_val = w_q;
      else if (hit_whi)  rd_val = whi_q;
      else if (hit_l)    rd_val = l_q;
      else if (hit_ctrl) rd_val = DATA_W'({err, busy, ready, valid});
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_MULT;
         S_MULT:  if (mul_cnt == MC_W'(OP_W - 1)) state_d = S_COUNT;
         S_COUNT: if (sl_cnt == SC_W'(N_SL - 1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         rd_sy          <= '0;
         wr_sy          <= '0;
         lt_sy          <= '0;
         sdata_out      <= '0;
         gpio_in_s_insp <= '0;
         a1_q           <= '0;
         a2_q           <= '0;
         mcand          <= '0;
         mplier         <= '0;
         acc            <= '0;
         w_q            <= '0;
         whi_q          <= '0;
         l_q            <= '0;
         pc_sh          <= '0;
         mul_cnt        <= '0;
         sl_cnt         <= '0;
         err            <= 1'b0;
         busy           <= 1'b0;
         ready          <= 1'b1;
         valid          <= 1'b1;
         op_count       <= '0;
      end else begin
         rd_sy <= {rd_sy[1:0], srd};
         wr_sy <= {wr_sy[1:0], swr};
         lt_sy <= {lt_sy[1:0], gpio_latch};

         if (lt_edge) gpio_in_s_insp <= gpio_in;
         if (rd_edge) sdata_out <= rd_val;

         if (wr_edge && !busy) begin
            if (hit_a1) a1_q <= OP_W'(sdata_in);
            if (hit_a2) a2_q <= OP_W'(sdata_in);
         end

         // A start that arrives while an operation is in flight only raises err.
         if (start && busy) err <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  busy    <= 1'b1;
                  ready   <= 1'b0;
                  err     <= 1'b0;
                  acc     <= '0;
                  l_q     <= '0;
                  mcand   <= P_W'(a1_q);
                  mplier  <= a2_q;
                  mul_cnt <= '0;
               end
            end
            S_MULT: begin
               acc     <= acc_nxt;
               mcand   <= mcand << 1;
               mplier  <= mplier >> 1;
               mul_cnt <= mul_cnt + 1'b1;
               if (mul_cnt == MC_W'(OP_W - 1)) begin
                  w_q    <= acc_nxt[DATA_W-1:0];
                  whi_q  <= DATA_W'(acc_nxt >> DATA_W);
                  valid  <= (DATA_W'(acc_nxt >> DATA_W) == '0);
                  pc_sh  <= acc_nxt[DATA_W-1:0];
                  sl_cnt <= '0;
               end
            end
            S_COUNT: begin
               l_q    <= l_q + slice_pop;
               pc_sh  <= pc_sh >> PC_STEP;
               sl_cnt <= sl_cnt + 1'b1;
            end
            S_DONE: begin
               busy     <= 1'b0;
               ready    <= 1'b1;
               op_count <= op_count + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_mulcnt_acc.sv
// tb/tb_gpio_mulcnt_acc.sv - directed scoreboard bench for gpio_mulcnt_acc
`timescale 1ns/1ps
module tb_gpio_mulcnt_acc;
   localparam logic [15:0] A_A1   = 16'h0380;
   localparam logic [15:0] A_A2   = 16'h0388;
   localparam logic [15:0] A_W    = 16'h0390;
   localparam logic [15:0] A_L    = 16'h0398;
   localparam logic [15:0] A_CTRL = 16'h03A0;
   localparam logic [15:0] A_WHI  = 16'h03A8;
   localparam logic [15:0] A_NONE = 16'h03B0;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic [15:0] saddress = '0;
   logic        srd = 1'b0;
   logic        swr = 1'b0;
   logic [31:0] sdata_in = '0;
   logic [31:0] sdata_out;
   logic [31:0] gpio_in = '0;
   logic        gpio_latch = 1'b0;
   logic [31:0] gpio_out;
   logic [31:0] gpio_in_s_insp;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [15:0] n_ops = '0;
   logic [31:0] exp_q[$];
   logic [31:0] msk_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   gpio_mulcnt_acc dut (
      .clk            (clk),
      .n_reset        (n_reset),
      .saddress       (saddress),
      .srd            (srd),
      .swr            (swr),
      .sdata_in       (sdata_in),
      .sdata_out      (sdata_out),
      .gpio_in        (gpio_in),
      .gpio_latch     (gpio_latch),
      .gpio_out       (gpio_out),
      .gpio_in_s_insp (gpio_in_s_insp)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      saddress = a;
      sdata_in = d;
      swr = 1'b1;
      repeat (4) @(negedge clk);
      swr = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic bus_rd(input logic [15:0] a, input logic [31:0] exp, input logic [31:0] msk,
                         input string tag);
      logic [31:0] e, m;
      string       t;
      exp_q.push_back(exp);
      msk_q.push_back(msk);
      tag_q.push_back(tag);
      @(negedge clk);
      saddress = a;
      srd = 1'b1;
      repeat (3) @(negedge clk);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      t = tag_q.pop_front();
      check(t, sdata_out & m, e & m);
      srd = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic run_op(input logic [23:0] a1, input logic [23:0] a2);
      bus_wr(A_A1, {8'h00, a1});
      bus_wr(A_A2, {8'h00, a2});
      bus_wr(A_CTRL, 32'h0);
      repeat (32) @(negedge clk);
      n_ops = n_ops + 16'd1;
   endtask

   task automatic check_result(input logic [23:0] a1, input logic [23:0] a2, input logic err_exp,
                               input string tag);
      logic [47:0] p;
      logic [31:0] lo, hi;
      p  = {24'h0, a1} * {24'h0, a2};
      lo = p[31:0];
      hi = {16'h0, p[47:32]};
      bus_rd(A_W,    lo, 32'hFFFF_FFFF, {tag, "_w"});
      bus_rd(A_WHI,  hi, 32'hFFFF_FFFF, {tag, "_whi"});
      bus_rd(A_L,    32'($countones(lo)), 32'hFFFF_FFFF, {tag, "_l"});
      bus_rd(A_CTRL, {28'h0, err_exp, 1'b0, 1'b1, (hi == 32'h0)}, 32'hFFFF_FFFF, {tag, "_stat"});
      check({tag, "_gpio_out"}, gpio_out, {16'h0, n_ops});
   endtask

   initial begin
      // Reset state
      #1;
      check("rst_sdata_out", sdata_out, 32'h0);
      check("rst_gpio_out", gpio_out, 32'h0);
      check("rst_insp", gpio_in_s_insp, 32'h0);
      @(negedge clk);
      @(negedge clk);
      n_reset = 1'b1;
      bus_rd(A_CTRL, 32'h3, 32'hFFFF_FFFF, "rst_stat");
      bus_rd(A_W,    32'h0, 32'hFFFF_FFFF, "rst_w");
      bus_rd(A_WHI,  32'h0, 32'hFFFF_FFFF, "rst_whi");

      // T1: 3*5 with exact start-to-ready latency observed on gpio_out
      bus_wr(A_A1, 32'd3);
      bus_wr(A_A2, 32'd5);
      @(negedge clk);
      saddress = A_CTRL;
      swr = 1'b1;
      repeat (4) @(negedge clk);
      swr = 1'b0;
      repeat (27) @(negedge clk);
      check("t1_lat_before", gpio_out, {16'h0, n_ops});
      @(negedge clk);
      n_ops = n_ops + 16'd1;
      check("t1_lat_after", gpio_out, {16'h0, n_ops});
      check_result(24'd3, 24'd5, 1'b0, "t1");
      bus_rd(A_NONE, 32'h0, 32'hFFFF_FFFF, "t1_unmapped");

      // T2: full-scale operands overflow DATA_W
      run_op(24'hFF_FFFF, 24'hFF_FFFF);
      check_result(24'hFF_FFFF, 24'hFF_FFFF, 1'b0, "t2");

      // T3: zero product, then an immediate second start is accepted
      run_op(24'h0, 24'h12_3456);
      check_result(24'h0, 24'h12_3456, 1'b0, "t3");
      bus_wr(A_CTRL, 32'h0);
      repeat (32) @(negedge clk);
      n_ops = n_ops + 16'd1;
      check_result(24'h0, 24'h12_3456, 1'b0, "t3b");

      // T4: start and operand write while busy
      bus_wr(A_A1, 32'h1234);
      bus_wr(A_A2, 32'h56);
      bus_wr(A_CTRL, 32'h0);
      bus_wr(A_CTRL, 32'h0);
      bus_wr(A_A1, 32'hFFFF);
      bus_rd(A_CTRL, 32'hC, 32'hE, "t4_stat_busy");
      repeat (32) @(negedge clk);
      n_ops = n_ops + 16'd1;
      check_result(24'h1234, 24'h56, 1'b1, "t4");
      run_op(24'd1, 24'd1);
      check_result(24'd1, 24'd1, 1'b0, "t4_clr");

      // GPIO capture before reset so the reset clear is visible
      @(negedge clk);
      gpio_in = 32'h1357_9BDF;
      gpio_latch = 1'b1;
      repeat (3) @(negedge clk);
      check("latch1", gpio_in_s_insp, 32'h1357_9BDF);
      gpio_latch = 1'b0;
      repeat (3) @(negedge clk);

      // T5: reset during MULT
      bus_wr(A_A1, 32'h0A_BCDE);
      bus_wr(A_A2, 32'h13);
      bus_wr(A_CTRL, 32'h0);
      repeat (5) @(negedge clk);
      n_reset = 1'b0;
      #1;
      n_ops = '0;
      check("t5_sdata_out", sdata_out, 32'h0);
      check("t5_gpio_out", gpio_out, 32'h0);
      check("t5_insp", gpio_in_s_insp, 32'h0);
      @(negedge clk);
      n_reset = 1'b1;
      bus_rd(A_CTRL, 32'h3, 32'hFFFF_FFFF, "t5_stat");
      bus_rd(A_W,    32'h0, 32'hFFFF_FFFF, "t5_w");
      bus_rd(A_L,    32'h0, 32'hFFFF_FFFF, "t5_l");
      run_op(24'd7, 24'd6);
      check_result(24'd7, 24'd6, 1'b0, "t5_after");

      // T6: op counter wrap and GPIO latch
      @(negedge clk);
      force dut.op_count = 16'hFFFF;
      @(negedge clk);
      release dut.op_count;
      n_ops = 16'hFFFF;
      check("t6_preload", gpio_out, 32'h0000_FFFF);
      run_op(24'd2, 24'd2);
      check_result(24'd2, 24'd2, 1'b0, "t6");
      @(negedge clk);
      gpio_in = 32'hA5A5_A5A5;
      gpio_latch = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_latch_early", gpio_in_s_insp, 32'h1357_9BDF & 32'h0);
      @(negedge clk);
      check("t6_latch", gpio_in_s_insp, 32'hA5A5_A5A5);
      gpio_latch = 1'b0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
